pipelined_subtractor: RTL and testbench
=======================================

Name: pipelined_subtractor

Overview:
Pipelined ripple-borrow subtractor computing diff = a - b - bi, the inverse datapath to the team's pipelined adder. Operands are split into CHUNK-bit slices, and each pipeline stage resolves one slice, so there is one borrow ripple per stage. Input and output are valid/ready handshaked with a single global stall. The block sits in the same arithmetic datapath as the adder, which it feeds or checks.

Parameters:
WIDTH, 8, operand/result width; must be a multiple of CHUNK (elaboration error otherwise)
CHUNK, 2, bits resolved per pipeline stage; 1 <= CHUNK <= WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bi  input  1  borrow in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
diff  output  WIDTH  a - b - bi, modulo 2^WIDTH
bo  output  1  borrow out; 1 when a < b + bi (unsigned)

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port rst, sampled on the rising edge of clk.
- NSTAGES = WIDTH/CHUNK. The pipeline is stage 0 (input register) followed by stages 1..NSTAGES (one slice each). The final stage register drives diff, bo and out_valid directly.
- Global enable en = !out_valid || out_ready. in_ready = en (combinational). No other combinational in->out path.
- When en=1, every stage register loads from its predecessor. When en=0, every register, including all valid bits, holds.
- Stage 0 captures a, b, bi and in_valid when en=1. A beat transfers when in_valid && in_ready.
- Stage k (1..NSTAGES) computes {borrow_k, d_k} = a[kC-1:(k-1)C] - b[kC-1:(k-1)C] - borrow_{k-1}, with borrow_0 = bi and C = CHUNK, using a (CHUNK+1)-bit unsigned subtract.
  - It forwards the unresolved upper slices of a/b.
  - It forwards the already-resolved lower diff bits, so diff is skew-aligned.
  - It forwards the valid bit.
- bo = borrow_NSTAGES.
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+NSTAGES when no stall occurs (default 4 cycles from acceptance to out_valid). Throughput is 1 beat/cycle when out_ready is held 1.
- Bubbles: in_valid=0 on an enabled cycle inserts a valid=0 slot that propagates. diff/bo are don't-care while out_valid=0; the bench checks them only on out_valid.
- Stall: out_valid=1 with out_ready=0 freezes the whole pipe. diff/bo stay stable and in_ready=0. Beats are never dropped or duplicated.
- Full pipe: up to NSTAGES+1 beats in flight; no skid buffer.
- Reset:
  - All valid bits go to 0; diff, bo and all data registers go to 0.
  - After reset, out_valid=0 and in_ready=1.
  - Reset mid-operation discards all in-flight beats.
  - rst has priority over en.
- Simultaneous output accept and input accept in one cycle is legal and is the normal streaming case.

Optional Feature:
PIPESUB_OVF_EN
- Defined: adds output port ovf (1 bit), carried in the final stage and reset to 0. ovf = signed two's-complement overflow of a - b - bi, i.e. (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). The sign bits are carried alongside the pipeline so they are aligned with diff. ovf follows the same valid/stall rules as diff.
- Undefined: no ovf port and no related registers.

Decomposition:
- pipesub_pkg contains:
  - function/localparam deriving NSTAGES from WIDTH and CHUNK
  - a typedef for the per-stage bundle {valid, a_hi, b_hi, diff_lo, borrow}
  - the elaboration-time WIDTH % CHUNK check helper
- Sub-module pipesub_stage: one registered CHUNK-bit slice with enable and sync reset, parameterized by stage index. The top module instantiates it NSTAGES times via generate.

Test Plan:
- Reset, then a=8'h35, b=8'h12, bi=0, out_ready=1 held -> exactly 4 cycles after acceptance: out_valid=1, diff=8'h23, bo=0.
- a=8'h00, b=8'h01, bi=0 -> diff=8'hFF, bo=1. With PIPESUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bo=0.
- a=8'h10, b=8'h0F, bi=1 -> diff=8'h00, bo=0. a=8'h0F, b=8'h0F, bi=1 -> diff=8'hFF, bo=1.
- Stream 64 random back-to-back beats with out_ready=1 -> results in order, one per cycle, each matching the reference model; in_ready never drops.
- Stream while out_ready toggles pseudo-randomly (including 10 consecutive low cycles) -> no beat lost, duplicated or reordered; diff/bo stable while stalled; in_ready == !out_valid || out_ready every cycle.
- Fill the pipe with 5 beats, assert rst for 1 cycle -> next cycle out_valid=0, diff=0, bo=0, in_ready=1; no stale beat ever emerges afterwards.

Source files
------------

// File: rtl/pipesub_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-borrow subtractor.
package pipesub_pkg;

    // Widest operand the per-stage bundle can carry.
    localparam int PIPESUB_MAX_W = 64;

    typedef struct packed {
        logic                     valid;
        logic [PIPESUB_MAX_W-1:0] a_hi;
        logic [PIPESUB_MAX_W-1:0] b_hi;
        logic [PIPESUB_MAX_W-1:0] diff_lo;
        logic                     borrow;
    } pipesub_bundle_t;

    function automatic int pipesub_nstages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit pipesub_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && (width <= PIPESUB_MAX_W)
               && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipesub_stage.sv
// One pipeline slice: resolves CHUNK bits of a - b - borrow and forwards the rest.
module pipesub_stage
    import pipesub_pkg::*;
#(
    parameter int K     = 1,
    parameter int CHUNK = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  pipesub_bundle_t prev,
    output pipesub_bundle_t q
);

    logic [CHUNK:0]  res;
    pipesub_bundle_t nxt;

    // a_hi/b_hi arrive right-aligned, so the slice to resolve is always the low CHUNK bits.
    always_comb begin
        res = {1'b0, prev.a_hi[CHUNK-1:0]}
            - {1'b0, prev.b_hi[CHUNK-1:0]}
            - {{CHUNK{1'b0}}, prev.borrow};
        nxt.valid   = prev.valid;
        nxt.a_hi    = prev.a_hi >> CHUNK;
        nxt.b_hi    = prev.b_hi >> CHUNK;
        nxt.diff_lo = prev.diff_lo | (PIPESUB_MAX_W'(res[CHUNK-1:0]) << ((K - 1) * CHUNK));
        nxt.borrow  = res[CHUNK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined ripple-borrow subtractor, diff = a - b - bi, one CHUNK slice per stage.
// Define PIPESUB_OVF_EN to add the aligned signed-overflow output ovf.
module pipelined_subtractor
    import pipesub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef PIPESUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bo
);

    localparam int NSTAGES = pipesub_nstages(WIDTH, CHUNK);

    if (!pipesub_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_subtractor: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH <= 64");
    end

    pipesub_bundle_t s0_q;
    pipesub_bundle_t stg_q [1:NSTAGES];
    pipesub_bundle_t last;
    logic            en;

    assign last      = stg_q[NSTAGES];
    assign en        = !last.valid || out_ready;
    assign in_ready  = en;
    assign out_valid = last.valid;
    assign diff      = last.diff_lo[WIDTH-1:0];
    assign bo        = last.borrow;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= '0;
        end else if (en) begin
            s0_q <= '{valid:   in_valid,
                      a_hi:    PIPESUB_MAX_W'(a),
                      b_hi:    PIPESUB_MAX_W'(b),
                      diff_lo: '0,
                      borrow:  bi};
        end
    end

    for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
        pipesub_bundle_t prev;
        if (k == 1) begin : g_first
            assign prev = s0_q;
        end else begin : g_rest
            assign prev = stg_q[k-1];
        end
        pipesub_stage #(.K(k), .CHUNK(CHUNK)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .prev (prev),
            .q    (stg_q[k])
        );
    end

    // After the last slice the operand fields are exhausted; only diff/borrow matter.
    logic unused_last;
    if (WIDTH < PIPESUB_MAX_W) begin : g_unused_hi
        assign unused_last = ^{last.a_hi, last.b_hi, last.diff_lo[PIPESUB_MAX_W-1:WIDTH]};
    end else begin : g_unused_full
        assign unused_last = ^{last.a_hi, last.b_hi};
    end

`ifdef PIPESUB_OVF_EN
    logic [NSTAGES:0] a_sgn;
    logic [NSTAGES:0] b_sgn;

    // Operand sign bits travel alongside the slices so they line up with diff's MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sgn <= '0;
            b_sgn <= '0;
        end else if (en) begin
            a_sgn <= {a_sgn[NSTAGES-1:0], a[WIDTH-1]};
            b_sgn <= {b_sgn[NSTAGES-1:0], b[WIDTH-1]};
        end
    end

    assign ovf = (a_sgn[NSTAGES] != b_sgn[NSTAGES]) && (diff[WIDTH-1] != a_sgn[NSTAGES]);
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: vector table, random streams, stalls, reset flush.
module tb_pipelined_subtractor;

    localparam int NST = 4;
    localparam int NV  = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bo;
`ifdef PIPESUB_OVF_EN
    logic       ovf;
`endif

    typedef struct {
        logic [7:0] diff;
        logic       bo;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } vec_t;

    exp_t       sb[$];
    exp_t       cur_exp;
    vec_t       vec[NV];
    int         errors = 0;
    int         checks = 0;
    logic       stalled = 1'b0;
    logic [7:0] held_diff;
    logic       held_bo;
    int         lat;

    pipelined_subtractor #(.WIDTH(8), .CHUNK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef PIPESUB_OVF_EN
        .ovf       (ovf),
`endif
        .bo        (bo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        exp_t       e;
        logic [8:0] r;
        int         s;
        r      = {1'b0, x} - {1'b0, y} - {8'b0, c};
        e.diff = r[7:0];
        e.bo   = r[8];
        s      = int'($signed(x)) - int'($signed(y)) - int'(c);
        e.ovf  = (s < -128) || (s > 127);
        return e;
    endfunction

    // Observe at the falling edge, then advance to 1ns after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            chk("in_ready_rel", in_ready, !out_valid || out_ready);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_diff", diff, held_diff);
                chk("stall_bo", bo, held_bo);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat diff=%0h bo=%0b, expected no beat", diff, bo);
                end else begin
                    e = sb.pop_front();
                    chk("sb_diff", diff, e.diff);
                    chk("sb_bo", bo, e.bo);
`ifdef PIPESUB_OVF_EN
                    chk("sb_ovf", ovf, e.ovf);
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            stalled   = out_valid && !out_ready;
            held_diff = diff;
            held_bo   = bo;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic v);
        a        = 8'($urandom_range(0, 255));
        b        = 8'($urandom_range(0, 255));
        bi       = 1'($urandom_range(0, 1));
        in_valid = v;
        cur_exp  = model(a, b, bi);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) step();
        chk("drain_empty", sb.size(), 0);
        step();
        step();
    endtask

    initial begin
        vec[0]  = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        vec[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vec[2]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vec[3]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vec[4]  = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[5]  = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
        vec[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[7]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[8]  = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
        vec[9]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[10] = '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0};
        vec[11] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[12] = '{8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bi        = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '{8'h00, 1'b0, 1'b0};
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_diff", diff, 0);
        chk("reset_bo", bo, 0);
`ifdef PIPESUB_OVF_EN
        chk("reset_ovf", ovf, 0);
`endif

        // Single beat latency
        a        = 8'h35;
        b        = 8'h12;
        bi       = 1'b0;
        in_valid = 1'b1;
        cur_exp  = '{8'h23, 1'b0, 1'b0};
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, NST);
        chk("lat_diff", diff, 8'h23);
        chk("lat_bo", bo, 0);
        drain();

        // Vector table, back to back
        for (int i = 0; i < NV; i++) begin
            a        = vec[i].a;
            b        = vec[i].b;
            bi       = vec[i].bi;
            in_valid = 1'b1;
            cur_exp  = '{vec[i].d, vec[i].bo, vec[i].ovf};
            step();
        end
        drain();

        // Random full-rate stream
        for (int i = 0; i < 64; i++) begin
            drive_rand(1'b1);
            step();
            chk("stream_in_ready", in_ready, 1);
            if (i >= NST) chk("stream_out_valid", out_valid, 1);
        end
        drain();

        // Random backpressure with a forced 10-cycle stall
        for (int i = 0; i < 100; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            out_ready = (i >= 30 && i < 40) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Reset with a full pipe
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_diff", diff, 0);
        chk("flush_bo", bo, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("flush_quiet", out_valid, 0);
        end

        // Pipe still works after the flush
        a        = 8'h80;
        b        = 8'h01;
        bi       = 1'b0;
        in_valid = 1'b1;
        cur_exp  = '{8'h7F, 1'b0, 1'b1};
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
